// File: rtl/axi4_master_ctrl.sv
// axi4_master_ctrl: turns one client command into a single AXI4 INCR burst (write or read),
// streaming beats through valid/ready pass-through ports and pulsing done with the final response.
module axi4_master_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              done,
  output logic [1:0]        resp,
  output logic              rlast_err,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [1:0]        resp_q, resp_d;
  logic              rlast_err_q, rlast_err_d;
  logic              awvalid_q, awvalid_d, arvalid_q, arvalid_d;
  logic [12:0]       burst_end;
  logic              illegal, last_beat, w_beat, r_beat;
  // 13-bit end address so a burst ending exactly on the 4 KB line stays legal
  assign burst_end = {1'b0, cmd_addr[11:0]} + {3'b000, cmd_len, 2'b00} + 13'd4;
  assign illegal   = (cmd_addr[1:0] != 2'b00) || (burst_end > 13'd4096);
  assign last_beat = cnt_q == {1'b0, len_q};
  assign w_beat    = (state_q == S_W) && wr_valid && WREADY;
  assign r_beat    = (state_q == S_R) && RVALID && rd_ready;
  always_comb begin
    state_d = state_q; addr_d = addr_q; len_d = len_q; cnt_d = cnt_q;
    resp_d = resp_q; rlast_err_d = rlast_err_q; awvalid_d = awvalid_q; arvalid_d = arvalid_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d = cmd_addr; len_d = cmd_len; cnt_d = '0;
        resp_d = illegal ? 2'b10 : 2'b00; rlast_err_d = 1'b0;
        awvalid_d = !illegal && cmd_write;
        arvalid_d = !illegal && !cmd_write;
        state_d = illegal ? S_DONE : cmd_write ? S_AW : S_AR;
      end
      S_AW: if (AWREADY) begin awvalid_d = 1'b0; state_d = S_W; end
      S_W: if (w_beat) begin
        cnt_d = cnt_q + 9'd1;
        state_d = last_beat ? S_B : S_W;
      end
      S_B: if (BVALID) begin resp_d = BRESP; state_d = S_DONE; end
      S_AR: if (ARREADY) begin arvalid_d = 1'b0; state_d = S_R; end
      S_R: if (r_beat) begin
        cnt_d = cnt_q + 9'd1;
        resp_d = (RRESP > resp_q) ? RRESP : resp_q;
        rlast_err_d = rlast_err_q | (RLAST != last_beat);
        state_d = last_beat ? S_DONE : S_R;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE; addr_q <= '0; len_q <= '0; cnt_q <= '0;
      resp_q <= 2'b00; rlast_err_q <= 1'b0; awvalid_q <= 1'b0; arvalid_q <= 1'b0;
    end else begin
      state_q <= state_d; addr_q <= addr_d; len_q <= len_d; cnt_q <= cnt_d;
      resp_q <= resp_d; rlast_err_q <= rlast_err_d; awvalid_q <= awvalid_d; arvalid_q <= arvalid_d;
    end
  end
  assign cmd_ready = state_q == S_IDLE;
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign AWLEN     = len_q;
  assign ARLEN     = len_q;
  assign AWSIZE    = 3'b010;
  assign ARSIZE    = 3'b010;
  assign AWVALID   = awvalid_q;
  assign ARVALID   = arvalid_q;
  assign WDATA     = wr_data;
  assign WVALID    = (state_q == S_W) && wr_valid;
  assign WLAST     = (state_q == S_W) && last_beat;
  assign wr_ready  = (state_q == S_W) && WREADY;
  assign BREADY    = state_q == S_B;
  assign rd_data   = RDATA;
  assign rd_valid  = (state_q == S_R) && RVALID;
  assign rd_last   = (state_q == S_R) && last_beat;
  assign RREADY    = (state_q == S_R) && rd_ready;
  assign done      = state_q == S_DONE;
  assign resp      = resp_q;
  assign rlast_err = rlast_err_q;
endmodule

// File: tb/tb_axi4_master_ctrl.sv
// tb_axi4_master_ctrl: directed scenarios against axi4_master_ctrl with a bench-driven AXI slave.
module tb_axi4_master_ctrl;
  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data, rd_data, WDATA, RDATA;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_last, done, rlast_err;
  logic [1:0]  resp, BRESP, RRESP;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] mem [0:255];

  always #5 ACLK = ~ACLK;

  axi4_master_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .resp(resp), .rlast_err(rlast_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic slave_idle();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0; cmd_valid = 0;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] l);
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
    #1;
  endtask

  task automatic test_reset();
    slave_idle(); cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    #2;
    n_checks++; if ({AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, wr_ready, rd_valid, rd_last, done} !== 10'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, wr_ready, rd_valid, rd_last, done}); end
    n_checks++; if ({resp, rlast_err} !== 3'b000) begin n_fail++; $display("FAIL reset_resp: got %b want 000", {resp, rlast_err}); end
    n_checks++; if ({AWADDR, ARADDR, AWLEN, ARLEN} !== 48'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", {AWADDR, ARADDR, AWLEN, ARLEN}); end
    n_checks++; if ({AWSIZE, ARSIZE} !== 6'b010010) begin n_fail++; $display("FAIL reset_size: got %b want 010010", {AWSIZE, ARSIZE}); end
    @(negedge ACLK); ARESETn = 1; #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    int wb = 0, done_cyc = -1, aw_cyc = -1;
    slave_idle();
    issue(1'b1, 16'h0100, 8'd3);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL write_cmd_ready: got %b want 1", cmd_ready); end
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(negedge ACLK);
      cmd_valid = 0; AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b00;
      wr_valid = (wb < 4); wr_data = 32'hA0 + wb;
      #1;
      if (AWVALID) begin
        if (aw_cyc < 0) aw_cyc = c;
        n_checks++; if ({AWADDR, AWLEN, AWSIZE} !== {16'h0100, 8'd3, 3'b010}) begin n_fail++; $display("FAIL write_aw_fields: got %h/%0d/%0d want 0100/3/2", AWADDR, AWLEN, AWSIZE); end
      end
      if (WVALID && WREADY) begin
        n_checks++; if (WDATA !== 32'hA0 + wb) begin n_fail++; $display("FAIL write_wdata: got %h want %h", WDATA, 32'hA0 + wb); end
        n_checks++; if (WLAST !== (wb == 3)) begin n_fail++; $display("FAIL write_wlast beat %0d: got %b want %b", wb, WLAST, wb == 3); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL write_wr_ready: got %b want 1", wr_ready); end
        mem[64 + wb] = WDATA;
        wb++;
      end
      if (done) begin
        done_cyc = c;
        n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL write_resp: got %b want 00", resp); end
      end
    end
    n_checks++; if (aw_cyc !== 1) begin n_fail++; $display("FAIL write_aw_cycle: got %0d want 1", aw_cyc); end
    n_checks++; if (wb !== 4) begin n_fail++; $display("FAIL write_beats: got %0d want 4", wb); end
    n_checks++; if (done_cyc !== 7) begin n_fail++; $display("FAIL write_done_cycle: got %0d want 7", done_cyc); end
  endtask

  task automatic test_read();
    int rb = 0, done_cyc = -1, ar_cyc = -1;
    slave_idle();
    issue(1'b0, 16'h0100, 8'd3);
    for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
      @(negedge ACLK);
      cmd_valid = 0; ARREADY = 1; RVALID = 1; RRESP = 2'b00;
      RDATA = (rb < 4) ? mem[64 + rb] : 32'h0; RLAST = (rb == 3);
      rd_ready = (c % 2 == 0);
      #1;
      if (ARVALID) begin
        if (ar_cyc < 0) ar_cyc = c;
        n_checks++; if ({ARADDR, ARLEN, ARSIZE} !== {16'h0100, 8'd3, 3'b010}) begin n_fail++; $display("FAIL read_ar_fields: got %h/%0d/%0d want 0100/3/2", ARADDR, ARLEN, ARSIZE); end
      end
      if (c == 1) begin
        n_checks++; if ({rd_valid, rd_last} !== 2'b00) begin n_fail++; $display("FAIL read_rd_valid_in_ar: got %b want 00", {rd_valid, rd_last}); end
      end
      if (rd_valid) begin
        n_checks++; if (rd_data !== 32'hA0 + rb) begin n_fail++; $display("FAIL read_data beat %0d: got %h want %h", rb, rd_data, 32'hA0 + rb); end
        n_checks++; if (rd_last !== (rb == 3)) begin n_fail++; $display("FAIL read_rd_last beat %0d: got %b want %b", rb, rd_last, rb == 3); end
        n_checks++; if (RREADY !== rd_ready) begin n_fail++; $display("FAIL read_rready: got %b want %b", RREADY, rd_ready); end
        if (RREADY) rb++;
      end
      if (done) begin
        done_cyc = c;
        n_checks++; if ({resp, rlast_err} !== 3'b000) begin n_fail++; $display("FAIL read_status: got %b want 000", {resp, rlast_err}); end
      end
    end
    n_checks++; if (ar_cyc !== 1) begin n_fail++; $display("FAIL read_ar_cycle: got %0d want 1", ar_cyc); end
    n_checks++; if (rb !== 4) begin n_fail++; $display("FAIL read_beats: got %0d want 4", rb); end
    n_checks++; if (done_cyc !== 9) begin n_fail++; $display("FAIL read_done_cycle: got %0d want 9", done_cyc); end
  endtask

  task automatic test_illegal();
    slave_idle(); AWREADY = 1; ARREADY = 1;
    issue(1'b1, 16'h0FF8, 8'd2);
    @(negedge ACLK); cmd_valid = 0; #1;
    n_checks++; if ({done, resp, AWVALID} !== 4'b1100) begin n_fail++; $display("FAIL illegal_4k: got done/resp/awvalid %b want 1100", {done, resp, AWVALID}); end
    @(negedge ACLK); #1;
    n_checks++; if ({done, cmd_ready, resp, AWVALID} !== 5'b01100) begin n_fail++; $display("FAIL illegal_4k_after: got %b want 01100", {done, cmd_ready, resp, AWVALID}); end
    issue(1'b0, 16'h0102, 8'd0);
    @(negedge ACLK); cmd_valid = 0; #1;
    n_checks++; if ({done, resp, ARVALID} !== 4'b1100) begin n_fail++; $display("FAIL illegal_align: got done/resp/arvalid %b want 1100", {done, resp, ARVALID}); end
  endtask

  task automatic test_read_err();
    int rb = 0, done_cyc = -1;
    slave_idle();
    issue(1'b0, 16'h0200, 8'd1);
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(negedge ACLK);
      cmd_valid = 0; ARREADY = 1; RVALID = 1; rd_ready = 1;
      RRESP = (rb == 0) ? 2'b00 : 2'b10; RLAST = (rb == 0); RDATA = 32'h1000 + rb;
      #1;
      if (c == 3) begin
        n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL rerr_resp_mid: got %b want 00", resp); end
      end
      if (rd_valid && RREADY) rb++;
      if (done) done_cyc = c;
    end
    n_checks++; if (done_cyc !== 4) begin n_fail++; $display("FAIL rerr_done_cycle: got %0d want 4", done_cyc); end
    n_checks++; if (rb !== 2) begin n_fail++; $display("FAIL rerr_beats: got %0d want 2", rb); end
    n_checks++; if ({resp, rlast_err} !== 3'b101) begin n_fail++; $display("FAIL rerr_status: got %b want 101", {resp, rlast_err}); end
    @(negedge ACLK); RVALID = 0; #1;
    n_checks++; if ({cmd_ready, resp, rlast_err} !== 4'b1101) begin n_fail++; $display("FAIL rerr_held: got %b want 1101", {cmd_ready, resp, rlast_err}); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, acc = -1, aw_seen = 0;
    slave_idle();
    issue(1'b0, 16'h0FFC, 8'd0);
    for (int c = 1; c <= 12 && d2 < 0; c++) begin
      @(negedge ACLK);
      ARREADY = 1; RVALID = 1; RDATA = 32'hBEEF; RLAST = 1; RRESP = 2'b00; rd_ready = 1;
      cmd_valid = (c >= 4 && acc < 0); cmd_write = 1; cmd_addr = 16'h0FFC; cmd_len = 8'd1;
      #1;
      if (c == 1) begin
        n_checks++; if ({ARVALID, ARADDR} !== {1'b1, 16'h0FFC}) begin n_fail++; $display("FAIL b2b_ar: got %b/%h want 1/0ffc", ARVALID, ARADDR); end
      end
      if (AWVALID) aw_seen = 1;
      if (cmd_valid && cmd_ready) acc = c;
      if (done && d1 < 0) begin
        d1 = c;
        n_checks++; if ({resp, rlast_err} !== 3'b000) begin n_fail++; $display("FAIL b2b_first_status: got %b want 000", {resp, rlast_err}); end
      end else if (done) begin
        d2 = c;
        n_checks++; if (resp !== 2'b10) begin n_fail++; $display("FAIL b2b_second_resp: got %b want 10", resp); end
      end
    end
    cmd_valid = 0;
    n_checks++; if ({d1, acc, d2} !== {32'd3, 32'd4, 32'd5}) begin n_fail++; $display("FAIL b2b_timing: got done1=%0d accept=%0d done2=%0d want 3/4/5", d1, acc, d2); end
    n_checks++; if (aw_seen !== 0) begin n_fail++; $display("FAIL b2b_no_aw: got %0d want 0", aw_seen); end
  endtask

  task automatic test_long_write();
    int wb = 0, done_cyc = -1, aw_n = 0, aw_bad = 0, wd_bad = 0, wlast_n = 0, wlast_at = -1, bwait = 0;
    slave_idle();
    issue(1'b1, 16'h0000, 8'd255);
    for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
      @(negedge ACLK);
      cmd_valid = 0; AWREADY = (c == 6); WREADY = 1; wr_valid = 1; wr_data = 32'h5000 + wb;
      BVALID = (c >= 265); BRESP = 2'b01;
      #1;
      if (AWVALID) begin
        aw_n++;
        if (AWADDR !== 16'h0000 || AWLEN !== 8'd255 || AWSIZE !== 3'b010) aw_bad++;
      end
      if (WVALID && WREADY) begin
        if (WDATA !== 32'h5000 + wb) wd_bad++;
        if (WLAST) begin wlast_n++; wlast_at = wb; end
        wb++;
      end
      if (BREADY && !BVALID) bwait++;
      if (done) done_cyc = c;
    end
    n_checks++; if (aw_n !== 6) begin n_fail++; $display("FAIL long_aw_cycles: got %0d want 6", aw_n); end
    n_checks++; if (aw_bad !== 0) begin n_fail++; $display("FAIL long_aw_stable: got %0d bad cycles want 0", aw_bad); end
    n_checks++; if (wb !== 256) begin n_fail++; $display("FAIL long_beats: got %0d want 256", wb); end
    n_checks++; if (wd_bad !== 0) begin n_fail++; $display("FAIL long_wdata: got %0d bad beats want 0", wd_bad); end
    n_checks++; if ({wlast_n, wlast_at} !== {32'd1, 32'd255}) begin n_fail++; $display("FAIL long_wlast: got count %0d at %0d want 1 at 255", wlast_n, wlast_at); end
    n_checks++; if (bwait !== 2) begin n_fail++; $display("FAIL long_bready_wait: got %0d want 2", bwait); end
    n_checks++; if (done_cyc !== 266) begin n_fail++; $display("FAIL long_done_cycle: got %0d want 266", done_cyc); end
    n_checks++; if (resp !== 2'b01) begin n_fail++; $display("FAIL long_resp: got %b want 01", resp); end
  endtask

  task automatic test_reset_mid();
    int done_cyc = -1, spurious = 0;
    slave_idle();
    issue(1'b1, 16'h0040, 8'd7);
    for (int c = 1; c <= 3; c++) begin
      @(negedge ACLK);
      cmd_valid = 0; AWREADY = 1; WREADY = 1; wr_valid = 1; wr_data = c;
      #1;
      if (done) spurious++;
    end
    n_checks++; if ({WVALID, WLAST} !== 2'b10) begin n_fail++; $display("FAIL rmid_in_w: got %b want 10", {WVALID, WLAST}); end
    ARESETn = 0; #1;
    n_checks++; if ({AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, wr_ready, rd_valid, rd_last, done} !== 10'b0) begin n_fail++; $display("FAIL rmid_drop: got %b want 0", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, wr_ready, rd_valid, rd_last, done}); end
    for (int c = 0; c < 2; c++) begin @(negedge ACLK); #1; if (done) spurious++; end
    slave_idle();
    @(negedge ACLK);
    ARESETn = 1; cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0100; cmd_len = 8'd0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_cmd_ready: got %b want 1", cmd_ready); end
    for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
      @(negedge ACLK);
      cmd_valid = 0; ARREADY = 1; RVALID = 1; RDATA = mem[64]; RLAST = 1; RRESP = 2'b00; rd_ready = 1;
      #1;
      if (rd_valid) begin
        n_checks++; if ({rd_data, rd_last} !== {32'hA0, 1'b1}) begin n_fail++; $display("FAIL rmid_read_beat: got %h/%b want a0/1", rd_data, rd_last); end
      end
      if (done) done_cyc = c;
    end
    n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", spurious); end
    n_checks++; if (done_cyc !== 3) begin n_fail++; $display("FAIL rmid_read_done: got %0d want 3", done_cyc); end
    n_checks++; if ({resp, rlast_err} !== 3'b000) begin n_fail++; $display("FAIL rmid_read_status: got %b want 000", {resp, rlast_err}); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_read_err();
    test_back_to_back();
    test_long_write();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
